// File: rtl/systolic_tile_sched_if.sv
// Command, array-control and drain handshake bundle for the systolic tile scheduler.
// master = command decoder / feeders / drain consumer, slave = scheduler.
interface systolic_tile_sched_if #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned K_W    = 12,
  parameter int unsigned STEP_W = K_W + 1,
  parameter int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic              start;
  logic              abort;
  logic [K_W-1:0]    k_len;
  logic              busy;
  logic              done;
  logic              clear_acc;
  logic              en;
  logic [STEP_W-1:0] step;
  logic [ROWS-1:0]   row_valid;
  logic [COLS-1:0]   col_valid;
  logic              drain_valid;
  logic [ROW_W-1:0]  drain_row;
  logic              drain_ready;

  modport master (
    output start, abort, k_len, drain_ready,
    input  busy, done, clear_acc, en, step, row_valid, col_valid, drain_valid, drain_row
  );

  modport slave (
    input  start, abort, k_len, drain_ready,
    output busy, done, clear_acc, en, step, row_valid, col_valid, drain_valid, drain_row
  );
endinterface

// File: rtl/systolic_tile_sched.sv
// Per-tile sequencer for an output-stationary systolic array: clear, skewed feed window
// with per-lane operand masks, then row-by-row accumulator drain over valid/ready.
module systolic_tile_sched #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned K_W    = 12,
  parameter int unsigned STEP_W = K_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_tile_sched_if.slave  bus
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SKEW  = ROWS + COLS - 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [K_W-1:0]    k_q;
  logic [STEP_W-1:0] feed_last_c;
  logic [STEP_W-1:0] step_next_c;
  logic [ROWS-1:0]   row_next_c;
  logic [COLS-1:0]   col_next_c;

  // Lane l carries real data at step t while its skewed index t-l lies in [0, K).
  function automatic logic lane_active(input logic [STEP_W-1:0] t,
                                       input int unsigned       lane,
                                       input logic [K_W-1:0]    k);
    return (t >= STEP_W'(lane)) && ((t - STEP_W'(lane)) < STEP_W'(k));
  endfunction

  // Step and masks for the coming cycle; step restarts at 0 on entry from CLEAR.
  always_comb begin
    feed_last_c = STEP_W'(k_q) + STEP_W'(SKEW) - STEP_W'(1);
    step_next_c = (state == FEED) ? bus.step + STEP_W'(1) : '0;
    row_next_c  = '0;
    col_next_c  = '0;
    for (int unsigned r = 0; r < ROWS; r++) row_next_c[r] = lane_active(step_next_c, r, k_q);
    for (int unsigned c = 0; c < COLS; c++) col_next_c[c] = lane_active(step_next_c, c, k_q);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state           <= IDLE;
      k_q             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.clear_acc   <= 1'b0;
      bus.en          <= 1'b0;
      bus.step        <= '0;
      bus.row_valid   <= '0;
      bus.col_valid   <= '0;
      bus.drain_valid <= 1'b0;
      bus.drain_row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= CLEAR;
            k_q           <= bus.k_len;
            bus.busy      <= 1'b1;
            bus.clear_acc <= 1'b1;
          end
        end

        // K == 0 skips the feed window so the consumer still drains the cleared tile.
        CLEAR: begin
          bus.clear_acc <= 1'b0;
          if (k_q != '0) begin
            state         <= FEED;
            bus.en        <= 1'b1;
            bus.step      <= step_next_c;
            bus.row_valid <= row_next_c;
            bus.col_valid <= col_next_c;
          end else begin
            state           <= DRAIN;
            bus.drain_valid <= 1'b1;
            bus.drain_row   <= '0;
          end
        end

        FEED: begin
          if (bus.step == feed_last_c) begin
            state           <= DRAIN;
            bus.en          <= 1'b0;
            bus.step        <= '0;
            bus.row_valid   <= '0;
            bus.col_valid   <= '0;
            bus.drain_valid <= 1'b1;
            bus.drain_row   <= '0;
          end else begin
            bus.step      <= step_next_c;
            bus.row_valid <= row_next_c;
            bus.col_valid <= col_next_c;
          end
        end

        DRAIN: begin
          if (bus.drain_ready) begin
            if (bus.drain_row == ROW_W'(ROWS - 1)) begin
              state           <= DONE;
              bus.drain_valid <= 1'b0;
              bus.drain_row   <= '0;
              bus.done        <= 1'b1;
            end else begin
              bus.drain_row <= bus.drain_row + ROW_W'(1);
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Scoreboard bench: tile launches push expected per-cycle control words and drain/done events;
// a negedge monitor feeds a 4x4 PE array model from the masks and compares everything.
module tb_systolic_tile_sched;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  systolic_tile_sched_if #(.ROWS(4), .COLS(4), .K_W(12), .STEP_W(13)) bus ();

  systolic_tile_sched #(.ROWS(4), .COLS(4), .K_W(12), .STEP_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        busy;
    logic        clr;
    logic        en;
    logic [12:0] step;
    logic [3:0]  rv;
    logic [3:0]  cv;
    logic        dv;
    logic [1:0]  drow;
    logic        done;
  } ctl_t;

  typedef struct {
    int   cyc;
    ctl_t v;
  } ctl_rec_t;

  typedef struct {
    int          cyc;
    bit          is_done;
    int          row;
    logic [31:0] acc;
  } ev_t;

  ctl_rec_t    ctl_q[$];
  ev_t         ev_q[$];
  int          mat_a[4][8];
  int          mat_b[8][4];
  logic [31:0] res[4];
  int          stall_from = 0;
  int          stall_to = 0;
  int          plan_end = 0;

  // PE array model state
  int acc[4][4];
  int ap[4][4];
  int bp[4][4];

  function automatic logic [3:0] lane_mask(input int t, input int k);
    logic [3:0] m;
    for (int l = 0; l < 4; l++) m[l] = (t >= l) && (t - l < k);
    return m;
  endfunction

  task automatic add_ctl(input int c, input ctl_t v, input int abort_cyc);
    ctl_rec_t rec;
    if (abort_cyc < 0 || c <= abort_cyc) begin
      rec.cyc = c;
      rec.v   = v;
      ctl_q.push_back(rec);
    end
  endtask

  task automatic add_ev(input int c, input bit is_done, input int row, input logic [31:0] a,
                        input int abort_cyc);
    ev_t e;
    if (abort_cyc < 0 || c <= abort_cyc) begin
      e.cyc = c; e.is_done = is_done; e.row = row; e.acc = a;
      ev_q.push_back(e);
    end
  endtask

  // Expected schedule of a tile started (start high) in cycle c0.
  task automatic plan(input int c0, input int k, input int srow, input int slen, input int abort_cyc);
    ctl_t v;
    int   c;
    int   len;
    int   hold;
    stall_from = 0;
    stall_to   = 0;
    v = '0; v.busy = 1'b1; v.clr = 1'b1;
    add_ctl(c0 + 1, v, abort_cyc);
    c = c0 + 2;
    len = k + 6;
    if (k > 0) begin
      for (int s = 0; s < len; s++) begin
        v = '0; v.busy = 1'b1; v.en = 1'b1; v.step = 13'(s);
        v.rv = lane_mask(s, k); v.cv = lane_mask(s, k);
        add_ctl(c, v, abort_cyc);
        c++;
      end
    end
    for (int r = 0; r < 4; r++) begin
      hold = (r == srow) ? slen + 1 : 1;
      if (r == srow) begin
        stall_from = c;
        stall_to   = c + slen;
      end
      for (int h = 0; h < hold; h++) begin
        v = '0; v.busy = 1'b1; v.dv = 1'b1; v.drow = 2'(r);
        add_ctl(c, v, abort_cyc);
        if (h == hold - 1) add_ev(c, 1'b0, r, res[r], abort_cyc);
        c++;
      end
    end
    v = '0; v.busy = 1'b1; v.done = 1'b1;
    add_ctl(c, v, abort_cyc);
    add_ev(c, 1'b1, 0, '0, abort_cyc);
    plan_end = c;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic launch(input int k, input int srow, input int slen, input int abort_step,
                        output int c0);
    int ab;
    c0 = cyc;
    ab = (abort_step < 0) ? -1 : c0 + 2 + abort_step;
    plan(c0, k, srow, slen, ab);
    bus.start = 1'b1;
    bus.k_len = 12'(k);
    next_cycle();
    bus.start = 1'b0;
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) begin
        mat_a[i][j] = 0;
        mat_b[j][i] = 0;
      end
  endtask

  task automatic set_identity();
    clear_mats();
    for (int i = 0; i < 4; i++) begin
      mat_a[i][i] = 1;
      mat_b[i][i] = 1;
    end
    res[0] = 32'h0000_0001; res[1] = 32'h0000_0100;
    res[2] = 32'h0001_0000; res[3] = 32'h0100_0000;
  endtask

  // A (4x3) and B (3x4); products worked by hand, byte c of res[r] = (A*B)[r][c].
  task automatic set_k3();
    clear_mats();
    mat_a[0][0] = 1; mat_a[0][1] = 2; mat_a[0][2] = 3;
    mat_a[1][1] = 1;
    mat_a[2][0] = 2; mat_a[2][2] = 1;
    mat_a[3][0] = 1; mat_a[3][1] = 1; mat_a[3][2] = 1;
    mat_b[0][0] = 1; mat_b[0][3] = 1;
    mat_b[1][1] = 1; mat_b[1][3] = 2;
    mat_b[2][2] = 1; mat_b[2][3] = 3;
    res[0] = 32'h0E03_0201; res[1] = 32'h0200_0100;
    res[2] = 32'h0501_0002; res[3] = 32'h0601_0101;
  endtask

  // Drain consumer: ready low only inside the planned stall window.
  initial begin
    bus.drain_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.drain_ready = !(cyc >= stall_from && cyc < stall_to);
    end
  end

  // Monitor: control word every cycle, drain/done events, and the PE array model.
  initial begin
    ctl_t        got;
    ctl_t        want;
    ev_t         e;
    logic [31:0] pk;
    int          ain[4][4];
    int          bin[4][4];
    int          idx;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc[r][c] = 0; ap[r][c] = 0; bp[r][c] = 0;
      end
    forever begin
      @(negedge clk);
      got = {bus.busy, bus.clear_acc, bus.en, bus.step, bus.row_valid, bus.col_valid,
             bus.drain_valid, bus.drain_row, bus.done};
      while (ctl_q.size() > 0 && ctl_q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL ctl_missed cyc=%0d want=%h", ctl_q[0].cyc, ctl_q[0].v);
        void'(ctl_q.pop_front());
      end
      want = '0;
      if (ctl_q.size() > 0 && ctl_q[0].cyc == cyc) want = ctl_q.pop_front().v;
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL ctl cyc=%0d got=%h want=%h", cyc, got, want);
      end

      if (bus.drain_valid === 1'b1 && bus.drain_ready === 1'b1) begin
        for (int c = 0; c < 4; c++) pk[8*c +: 8] = 8'(acc[int'(bus.drain_row)][c]);
        total++;
        if (ev_q.size() == 0 || ev_q[0].is_done) begin
          bad++;
          $display("FAIL drain_unexpected cyc=%0d row=%0d", cyc, bus.drain_row);
        end else begin
          e = ev_q.pop_front();
          if (e.cyc != cyc || e.row != int'(bus.drain_row) || e.acc !== pk) begin
            bad++;
            $display("FAIL drain cyc=%0d row=%0d acc=%h want cyc=%0d row=%0d acc=%h",
                     cyc, bus.drain_row, pk, e.cyc, e.row, e.acc);
          end
        end
      end

      if (bus.done === 1'b1) begin
        total++;
        if (ev_q.size() == 0 || !ev_q[0].is_done) begin
          bad++;
          $display("FAIL done_unexpected cyc=%0d", cyc);
        end else begin
          e = ev_q.pop_front();
          if (e.cyc != cyc) begin
            bad++;
            $display("FAIL done cyc=%0d want=%0d", cyc, e.cyc);
          end
        end
      end

      if (bus.clear_acc === 1'b1)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) acc[r][c] = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (c == 0) begin
            idx = int'(bus.step) - r;
            ain[r][c] = (bus.row_valid[r] === 1'b1 && idx >= 0 && idx < 8) ? mat_a[r][idx] : 0;
          end else begin
            ain[r][c] = ap[r][c-1];
          end
          if (r == 0) begin
            idx = int'(bus.step) - c;
            bin[r][c] = (bus.col_valid[c] === 1'b1 && idx >= 0 && idx < 8) ? mat_b[idx][c] : 0;
          end else begin
            bin[r][c] = bp[r-1][c];
          end
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (bus.en === 1'b1) acc[r][c] += ain[r][c] * bin[r][c];
          ap[r][c] = ain[r][c];
          bp[r][c] = bin[r][c];
        end
    end
  end

  initial begin
    int c0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.k_len = '0;
    clear_mats();
    repeat (3) next_cycle();
    rst = 1'b0;
    next_cycle();

    // K=3 tile; a stray start mid-feed with another K is ignored.
    set_k3();
    launch(3, -1, 0, -1, c0);
    wait_until(c0 + 5);
    bus.start = 1'b1; bus.k_len = 12'd9;
    next_cycle();
    bus.start = 1'b0;
    wait_until(plan_end + 3);

    // Identity operands, K=4.
    set_identity();
    launch(4, -1, 0, -1, c0);
    wait_until(plan_end + 3);

    // K=0: clear, then drain zeros with no feed window.
    set_k3();
    for (int r = 0; r < 4; r++) res[r] = '0;
    launch(0, -1, 0, -1, c0);
    wait_until(plan_end + 3);

    // Row 2 back-pressured for 5 cycles; start during the done cycle is ignored.
    set_k3();
    launch(3, 2, 5, -1, c0);
    wait_until(plan_end);
    bus.start = 1'b1; bus.k_len = 12'd2;
    next_cycle();
    bus.start = 1'b0;
    wait_until(plan_end + 4);

    // Abort at feed step 4 with a simultaneous start, then a clean tile.
    set_identity();
    launch(4, -1, 0, 4, c0);
    wait_until(c0 + 6);
    bus.abort = 1'b1; bus.start = 1'b1; bus.k_len = 12'd7;
    next_cycle();
    bus.abort = 1'b0; bus.start = 1'b0;
    repeat (6) next_cycle();
    launch(4, -1, 0, -1, c0);
    wait_until(plan_end + 3);

    // Abort together with start in IDLE: nothing launches.
    bus.abort = 1'b1; bus.start = 1'b1; bus.k_len = 12'd3;
    next_cycle();
    bus.abort = 1'b0; bus.start = 1'b0;
    repeat (5) next_cycle();

    // Maximum K: step runs to 4100 without wrapping.
    set_identity();
    launch(4095, -1, 0, -1, c0);
    wait_until(plan_end + 3);

    total++;
    if (ctl_q.size() != 0 || ev_q.size() != 0) begin
      bad++;
      $display("FAIL leftover ctl=%0d ev=%0d want 0", ctl_q.size(), ev_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
